// File: rtl/axi4_mem_responder.sv
// AXI4 subordinate backed by a word-addressed RAM. The write (AW/W/B) and
// read (AR/R) paths are independent state machines. Each path holds at most
// one outstanding transaction. Beats that fall outside the RAM, use WRAP
// bursts, or request an oversize beat are not performed and report SLVERR.
module axi4_mem_responder #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ID_W-1:0]       i_awid,
  input  logic [ADDR_W-1:0]     i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awlock,
  input  logic [3:0]            i_awcache,
  input  logic [2:0]            i_awprot,
  input  logic [3:0]            i_awqos,
  input  logic [3:0]            i_awregion,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_W-1:0]       o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ID_W-1:0]       i_arid,
  input  logic [ADDR_W-1:0]     i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arlock,
  input  logic [3:0]            i_arcache,
  input  logic [2:0]            i_arprot,
  input  logic [3:0]            i_arqos,
  input  logic [3:0]            i_arregion,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_W-1:0]       o_rid,
  output logic [DATA_W-1:0]     o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [2:0]      MAX_SIZE   = 3'(LANE_W);
  localparam logic [ADDR_W:0] MEM_BYTES  = (ADDR_W+1)'(MEM_WORDS * LANES);
  localparam logic [1:0]      BURST_INCR = 2'b01;
  localparam logic [1:0]      BURST_WRAP = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic       {R_IDLE, R_DATA}         rState_t;

  wState_t r_wState, w_wStateNext;
  rState_t r_rState, w_rStateNext;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic [ID_W-1:0]   r_awId;
  logic [ADDR_W-1:0] r_awAddr;
  logic [7:0]        r_awLen;
  logic [2:0]        r_awSize;
  logic [1:0]        r_awBurst;
  logic [7:0]        r_wBeat;
  logic              r_wPast;
  logic              r_wErr;

  logic [ID_W-1:0]   r_arId;
  logic [ADDR_W-1:0] r_arAddr;
  logic [7:0]        r_arLen;
  logic [2:0]        r_arSize;
  logic [1:0]        r_arBurst;
  logic [7:0]        r_rBeat;
  logic [DATA_W-1:0] r_rData;
  logic [1:0]        r_rResp;
  logic              r_rLast;

  logic              w_awHs, w_wHs, w_wBeatLegal, w_wCommit, w_wIsLast;
  logic [ADDR_W-1:0] w_wNextAddr;
  logic [IDX_W-1:0]  w_wIdx;
  logic              w_arHs, w_rHs, w_rLoadLegal;
  logic [ADDR_W-1:0] w_rNextAddr, w_rLoadAddr;
  logic [2:0]        w_rLoadSize;
  logic [1:0]        w_rLoadBurst;
  logic [IDX_W-1:0]  w_rIdx;
  logic              w_unused;

  assign w_unused = ^{i_awlock, i_awcache, i_awprot, i_awqos, i_awregion,
                      i_arlock, i_arcache, i_arprot, i_arqos, i_arregion};

  assign w_awHs       = i_awvalid && o_awready;
  assign w_wHs        = i_wvalid && o_wready;
  assign w_wBeatLegal = ({1'b0, r_awAddr} < MEM_BYTES) && (r_awBurst != BURST_WRAP)
                        && (r_awSize <= MAX_SIZE);
  assign w_wCommit    = w_wHs && w_wBeatLegal && !r_wPast;
  assign w_wIsLast    = (r_wBeat == r_awLen) && !r_wPast;
  assign w_wNextAddr  = (r_awBurst == BURST_INCR) ? r_awAddr + (ADDR_W'(1) << r_awSize) : r_awAddr;
  assign w_wIdx       = r_awAddr[LANE_W +: IDX_W];

  assign w_arHs       = i_arvalid && o_arready;
  assign w_rHs        = o_rvalid && i_rready;
  assign w_rNextAddr  = (r_arBurst == BURST_INCR) ? r_arAddr + (ADDR_W'(1) << r_arSize) : r_arAddr;
  assign w_rLoadAddr  = w_arHs ? i_araddr  : w_rNextAddr;
  assign w_rLoadSize  = w_arHs ? i_arsize  : r_arSize;
  assign w_rLoadBurst = w_arHs ? i_arburst : r_arBurst;
  assign w_rLoadLegal = ({1'b0, w_rLoadAddr} < MEM_BYTES) && (w_rLoadBurst != BURST_WRAP)
                        && (w_rLoadSize <= MAX_SIZE);
  assign w_rIdx       = w_rLoadAddr[LANE_W +: IDX_W];

  assign o_bid   = r_awId;
  assign o_bresp = r_wErr ? 2'b10 : 2'b00;
  assign o_rid   = r_arId;
  assign o_rdata = r_rData;
  assign o_rresp = r_rResp;
  assign o_rlast = r_rLast;

  // Write and read state registers; reset returns both paths to idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wState <= W_IDLE;
      r_rState <= R_IDLE;
    end else begin
      r_wState <= w_wStateNext;
      r_rState <= w_rStateNext;
    end
  end

  // Write path: next state and channel handshake outputs.
  always_comb begin
    w_wStateNext = r_wState;
    o_awready    = 1'b0;
    o_wready     = 1'b0;
    o_bvalid     = 1'b0;
    case (r_wState)
      W_IDLE: begin
        o_awready = 1'b1;
        if (i_awvalid) w_wStateNext = W_DATA;
      end
      W_DATA: begin
        o_wready = 1'b1;
        if (i_wvalid && i_wlast) w_wStateNext = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_wStateNext = W_IDLE;
      end
      default: w_wStateNext = W_IDLE;
    endcase
  end

  // Read path: next state and channel handshake outputs.
  always_comb begin
    w_rStateNext = r_rState;
    o_arready    = 1'b0;
    o_rvalid     = 1'b0;
    case (r_rState)
      R_IDLE: begin
        o_arready = 1'b1;
        if (i_arvalid) w_rStateNext = R_DATA;
      end
      R_DATA: begin
        o_rvalid = 1'b1;
        if (i_rready && r_rLast) w_rStateNext = R_IDLE;
      end
      default: w_rStateNext = R_IDLE;
    endcase
  end

  // Write bookkeeping: latch the request, walk the address, track sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_awId    <= '0;
      r_awAddr  <= '0;
      r_awLen   <= '0;
      r_awSize  <= '0;
      r_awBurst <= '0;
      r_wBeat   <= '0;
      r_wPast   <= 1'b0;
      r_wErr    <= 1'b0;
    end else if (w_awHs) begin
      r_awId    <= i_awid;
      r_awAddr  <= i_awaddr;
      r_awLen   <= i_awlen;
      r_awSize  <= i_awsize;
      r_awBurst <= i_awburst;
      r_wBeat   <= '0;
      r_wPast   <= 1'b0;
      r_wErr    <= 1'b0;
    end else if (w_wHs) begin
      r_awAddr <= w_wNextAddr;
      if (w_wIsLast) r_wPast <= 1'b1;
      else if (!r_wPast) r_wBeat <= r_wBeat + 8'd1;
      if ((!w_wBeatLegal && !r_wPast) || (i_wlast != w_wIsLast)) r_wErr <= 1'b1;
    end
  end

  // RAM write port: byte lanes enabled by the strobes; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wCommit) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_wstrb[i]) r_mem[w_wIdx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Read bookkeeping: preload the next beat so R data holds steady while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_arId    <= '0;
      r_arAddr  <= '0;
      r_arLen   <= '0;
      r_arSize  <= '0;
      r_arBurst <= '0;
      r_rBeat   <= '0;
      r_rData   <= '0;
      r_rResp   <= '0;
      r_rLast   <= 1'b0;
    end else if (w_arHs) begin
      r_arId    <= i_arid;
      r_arAddr  <= i_araddr;
      r_arLen   <= i_arlen;
      r_arSize  <= i_arsize;
      r_arBurst <= i_arburst;
      r_rBeat   <= '0;
      r_rData   <= w_rLoadLegal ? r_mem[w_rIdx] : '0;
      r_rResp   <= w_rLoadLegal ? 2'b00 : 2'b10;
      r_rLast   <= (i_arlen == 8'd0);
    end else if (w_rHs && !r_rLast) begin
      r_arAddr <= w_rNextAddr;
      r_rBeat  <= r_rBeat + 8'd1;
      r_rData  <= w_rLoadLegal ? r_mem[w_rIdx] : '0;
      r_rResp  <= w_rLoadLegal ? 2'b00 : 2'b10;
      r_rLast  <= ((r_rBeat + 8'd1) == r_arLen);
    end else if (w_rHs) begin
      r_rLast <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Self-checking bench for axi4_mem_responder: directed vector table, a few
// hand-written multi-cycle sequences, then randomized traffic checked
// against a byte-level memory model.
module tb_axi4_mem_responder;

  localparam int MEM_BYTES = 4096;
  localparam int BOUND     = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic        sideLock;
  logic [3:0]  sideCache, sideQos, sideRegion;
  logic [2:0]  sideProt;

  axi4_mem_responder dut (
    .i_clk(clk), .i_rst(rst),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_awlock(sideLock), .i_awcache(sideCache), .i_awprot(sideProt), .i_awqos(sideQos),
    .i_awregion(sideRegion), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arlock(sideLock), .i_arcache(sideCache), .i_arprot(sideProt), .i_arqos(sideQos),
    .i_arregion(sideRegion), .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
    .i_rready(rready)
  );

  typedef struct {
    bit          isWrite;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlastAt;
    logic [3:0]  strb;
    logic [31:0] data0;
    bit          stall;
    logic [1:0]  expResp;
    logic [31:0] expFirst;
    logic [31:0] expLast;
    logic [1:0]  expLastResp;
  } Vector;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [1024];

  // Compares one observed value with its expected value and keeps the tally.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=handshake", name);
  endtask

  function automatic logic [31:0] beatAddr(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst, input int b);
    logic [31:0] step;
    step = 32'd1 << size;
    return (burst == 2'd1) ? addr + step * 32'(b) : addr;
  endfunction

  function automatic bit beatOk(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    return (burst != 2'd2) && (size <= 3'd2) && (a < 32'(MEM_BYTES));
  endfunction

  function automatic void modelWrite(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      if (strb[k]) model[a[11:2]][8*k +: 8] = d[8*k +: 8];
  endfunction

  // Full write transaction; dataMode 0: data0+beat, 1: random, 2: constant data0.
  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int wlastAt,
                            input logic [3:0] strb, input logic [31:0] data0, input int dataMode,
                            output logic [1:0] bOut);
    int n;
    logic [31:0] d, a;
    bit expErr;
    bOut = 2'b11;
    expErr = (wlastAt != int'(len));
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < BOUND) begin @(negedge clk); n++; end
    if (!awready) begin timeoutFail("awHandshake"); awvalid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= wlastAt; b++) begin
      d = (dataMode == 0) ? data0 + 32'(b) : (dataMode == 1) ? $urandom : data0;
      wdata = d; wstrb = strb; wlast = (b == wlastAt); wvalid = 1'b1;
      n = 0;
      while (!wready && n < BOUND) begin @(negedge clk); n++; end
      if (!wready) begin timeoutFail("wHandshake"); wvalid = 1'b0; return; end
      if (b == 0) checkOutput("awReadyBusy", 64'(awready), 64'd0);
      @(posedge clk);
      a = beatAddr(addr, size, burst, b);
      if (b <= int'(len)) begin
        if (beatOk(a, size, burst)) modelWrite(a, strb, d);
        else expErr = 1'b1;
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < BOUND) begin @(negedge clk); n++; end
    if (!bvalid) begin timeoutFail("bHandshake"); bready = 1'b0; return; end
    bOut = bresp;
    checkOutput("bid", 64'(bid), 64'(id));
    checkOutput("bresp", 64'(bresp), expErr ? 64'd2 : 64'd0);
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    checkOutput("awReadyAfterB", 64'(awready), 64'd1);
  endtask

  // Full read transaction, every beat compared with the model; optional random rready.
  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall,
                           output logic [31:0] firstD, output logic [1:0] firstR,
                           output logic [31:0] lastD, output logic [1:0] lastR);
    int n, b, cyc;
    logic rr;
    logic [34:0] held;
    bit stalled, ok;
    logic [31:0] a, expD;
    firstD = '1; firstR = 2'b11; lastD = '1; lastR = 2'b11;
    held = '0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < BOUND) begin @(negedge clk); n++; end
    if (!arready) begin timeoutFail("arHandshake"); arvalid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("rLatency", 64'(rvalid), 64'd1);
    b = 0; cyc = 0; stalled = 1'b0;
    while (b <= int'(len) && cyc < BOUND) begin
      rr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rready = rr;
      if (rvalid) begin
        if (stalled) checkOutput("rStable", 64'({rdata, rresp, rlast}), 64'(held));
        if (rr) begin
          a = beatAddr(addr, size, burst, b);
          ok = beatOk(a, size, burst);
          expD = ok ? model[a[11:2]] : 32'd0;
          checkOutput($sformatf("rdata beat%0d", b), 64'(rdata), 64'(expD));
          checkOutput($sformatf("rresp beat%0d", b), 64'(rresp), ok ? 64'd0 : 64'd2);
          checkOutput($sformatf("rlast beat%0d", b), 64'(rlast), 64'(b == int'(len)));
          checkOutput("rid", 64'(rid), 64'(id));
          if (b == 0) begin firstD = rdata; firstR = rresp; end
          if (b == int'(len)) begin lastD = rdata; lastR = rresp; end
          b++;
          stalled = 1'b0;
        end else begin
          held = {rdata, rresp, rlast};
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (b <= int'(len)) timeoutFail("rBeats");
    else checkOutput("rIdleAfterLast", 64'({rvalid, arready}), 64'b01);
  endtask

  function automatic Vector mkW(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input int wlastAt,
                                input logic [3:0] strb, input logic [31:0] data0, input logic [1:0] expResp);
    Vector v;
    v = '{isWrite: 1'b1, id: id, addr: addr, len: len, size: size, burst: burst, wlastAt: wlastAt,
          strb: strb, data0: data0, stall: 1'b0, expResp: expResp, expFirst: '0, expLast: '0,
          expLastResp: '0};
    return v;
  endfunction

  function automatic Vector mkR(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input bit stall,
                                input logic [31:0] expFirst, input logic [1:0] expResp,
                                input logic [31:0] expLast, input logic [1:0] expLastResp);
    Vector v;
    v = '{isWrite: 1'b0, id: id, addr: addr, len: len, size: size, burst: burst, wlastAt: 0,
          strb: '0, data0: '0, stall: stall, expResp: expResp, expFirst: expFirst,
          expLast: expLast, expLastResp: expLastResp};
    return v;
  endfunction

  // Runs one table entry and compares it with the hand-derived expectations.
  task automatic applyStimulus(input int idx, input Vector v);
    logic [1:0]  br, fr, lr;
    logic [31:0] fd, ld;
    if (v.isWrite) begin
      writeBurst(v.id, v.addr, v.len, v.size, v.burst, v.wlastAt, v.strb, v.data0, 0, br);
      checkOutput($sformatf("vec%0d bresp", idx), 64'(br), 64'(v.expResp));
    end else begin
      readBurst(v.id, v.addr, v.len, v.size, v.burst, v.stall, fd, fr, ld, lr);
      checkOutput($sformatf("vec%0d firstData", idx), 64'(fd), 64'(v.expFirst));
      checkOutput($sformatf("vec%0d firstResp", idx), 64'(fr), 64'(v.expResp));
      checkOutput($sformatf("vec%0d lastData", idx), 64'(ld), 64'(v.expLast));
      checkOutput($sformatf("vec%0d lastResp", idx), 64'(lr), 64'(v.expLastResp));
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Vector       vecs[$];
    logic [1:0]  br, fr, lr;
    logic [31:0] fd, ld, addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          pick, wlastAt;

    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    sideLock = 1'b0; sideCache = 4'h3; sideProt = 3'h0; sideQos = 4'h0; sideRegion = 4'h0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rstReady", 64'({awready, arready}), 64'b11);
    checkOutput("rstValid", 64'({wready, bvalid, rvalid, rlast}), 64'd0);
    checkOutput("rstIds", 64'({bid, rid}), 64'd0);
    checkOutput("rstRdata", 64'(rdata), 64'd0);
    checkOutput("rstResp", 64'({bresp, rresp}), 64'd0);

    for (int q = 0; q < 4; q++)
      writeBurst(4'd0, 32'(q * 1024), 8'd255, 3'd2, 2'd1, 255, 4'hF, 32'd0, 2, br);

    vecs.push_back(mkW(4'd3, 32'h10,  8'd3, 3'd2, 2'd1, 3, 4'hF, 32'hA0, 2'd0));
    vecs.push_back(mkR(4'd3, 32'h10,  8'd3, 3'd2, 2'd1, 1'b0, 32'hA0, 2'd0, 32'hA3, 2'd0));
    vecs.push_back(mkW(4'd1, 32'h20,  8'd0, 3'd2, 2'd1, 0, 4'h3, 32'hDEADBEEF, 2'd0));
    vecs.push_back(mkR(4'd1, 32'h20,  8'd0, 3'd2, 2'd1, 1'b0, 32'h0000BEEF, 2'd0, 32'h0000BEEF, 2'd0));
    vecs.push_back(mkR(4'd2, 32'hFFC, 8'd1, 3'd2, 2'd1, 1'b0, 32'h0, 2'd0, 32'h0, 2'd2));
    vecs.push_back(mkW(4'd4, 32'h40,  8'd3, 3'd2, 2'd1, 2, 4'hF, 32'hB0, 2'd2));
    vecs.push_back(mkR(4'd4, 32'h40,  8'd3, 3'd2, 2'd1, 1'b0, 32'hB0, 2'd0, 32'h0, 2'd0));
    vecs.push_back(mkW(4'd5, 32'h60,  8'd2, 3'd2, 2'd0, 2, 4'hF, 32'h11, 2'd0));
    vecs.push_back(mkR(4'd5, 32'h60,  8'd0, 3'd2, 2'd1, 1'b0, 32'h13, 2'd0, 32'h13, 2'd0));
    vecs.push_back(mkW(4'd6, 32'h70,  8'd0, 3'd3, 2'd1, 0, 4'hF, 32'h77, 2'd2));
    vecs.push_back(mkR(4'd6, 32'h70,  8'd0, 3'd2, 2'd1, 1'b0, 32'h0, 2'd0, 32'h0, 2'd0));
    vecs.push_back(mkR(4'd7, 32'h10,  8'd1, 3'd2, 2'd2, 1'b0, 32'h0, 2'd2, 32'h0, 2'd2));
    vecs.push_back(mkW(4'd8, 32'h100, 8'd7, 3'd2, 2'd1, 7, 4'hF, 32'hC0, 2'd0));
    vecs.push_back(mkR(4'd8, 32'h100, 8'd7, 3'd2, 2'd1, 1'b1, 32'hC0, 2'd0, 32'hC7, 2'd0));
    vecs.push_back(mkW(4'd9, 32'h50,  8'd0, 3'd2, 2'd1, 0, 4'hF, 32'h12345678, 2'd0));
    vecs.push_back(mkR(4'd9, 32'h50,  8'd0, 3'd2, 2'd1, 1'b0, 32'h12345678, 2'd0, 32'h12345678, 2'd0));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    fork
      writeBurst(4'hA, 32'h300, 8'd3, 3'd2, 2'd1, 3, 4'hF, 32'hE0, 0, br);
      readBurst(4'hB, 32'h10, 8'd3, 3'd2, 2'd1, 1'b0, fd, fr, ld, lr);
      begin
        @(negedge clk);
        checkOutput("sameCycleReady", 64'({awready, arready}), 64'b11);
        @(negedge clk);
        checkOutput("sameCycleAccepted", 64'({wready, rvalid}), 64'b11);
      end
    join
    checkOutput("sameCycleReadLast", 64'(ld), 64'hA3);

    @(negedge clk);
    awid = 4'd6; awaddr = 32'h200; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    arid = 4'd7; araddr = 32'h200; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = 32'h5A0 + 32'(b); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      @(posedge clk);
      modelWrite(32'h200 + 32'(4 * b), 4'hF, 32'h5A0 + 32'(b));
      @(negedge clk);
    end
    wvalid = 1'b0;
    checkOutput("midBurstBusy", 64'({awready, arready, rvalid}), 64'b001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstReady", 64'({awready, arready}), 64'b11);
    checkOutput("midRstValid", 64'({wready, bvalid, rvalid}), 64'd0);
    readBurst(4'd2, 32'h200, 8'd3, 3'd2, 2'd1, 1'b0, fd, fr, ld, lr);
    checkOutput("partialBeatKept", 64'(fd), 64'h5A0);
    checkOutput("unwrittenBeat", 64'(ld), 64'h0);
    writeBurst(4'd3, 32'h210, 8'd1, 3'd2, 2'd1, 1, 4'hF, 32'h77, 0, br);
    checkOutput("postRstWrite", 64'(br), 64'd0);

    for (int t = 0; t < 60; t++) begin
      pick = $urandom_range(0, 9);
      if (pick < 7)       addr = 32'($urandom_range(0, MEM_BYTES - 1));
      else if (pick == 7) addr = 32'(MEM_BYTES - 16) + 32'($urandom_range(0, 15));
      else if (pick == 8) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                addr = 32'(MEM_BYTES) + 32'($urandom_range(0, 255));
      len  = 8'($urandom_range(0, 7));
      size = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'd3;
      burst = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        wlastAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len) + 2)) : int'(len);
        writeBurst(4'($urandom), addr, len, size, burst, wlastAt, 4'($urandom), 32'd0, 1, br);
      end else begin
        readBurst(4'($urandom), addr, len, size, burst, 1'($urandom_range(0, 1)), fd, fr, ld, lr);
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
